// File: rtl/kgp_risc_pkg.sv
// ============================================================================
// Module      : kgp_risc_pkg
// Description : Shared widths, register-address type and reg-file FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kgp_risc_pkg;

   localparam int unsigned c_dw = 32;
   localparam int unsigned c_aw = 5;

   typedef logic [c_aw-1:0] reg_addr_t;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : kgp_risc_pkg

`default_nettype wire

// File: rtl/reg_file_array.sv
// ============================================================================
// Module      : reg_file_array
// Description : 2^AW x DW storage, one synchronous write, two async reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_array
   import kgp_risc_pkg::*;
#(
   parameter int DW = c_dw,
   parameter int AW = c_aw
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [DW-1:0] o_rdata_a,
   output logic [DW-1:0] o_rdata_b
);

   // Deliberately unreset so the array maps onto distributed RAM.
   logic [DW-1:0] r_mem [0:(2**AW)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule : reg_file_array

`default_nettype wire

// File: rtl/reg_file_rw.sv
// ============================================================================
// Module      : reg_file_rw
// Description : 32x32 register file, registered dual read with write bypass,
//               zeroing sweep after reset before READY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_rw
   import kgp_risc_pkg::*;
#(
   parameter int DW = c_dw,
   parameter int AW = c_aw
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          WE,
   input  logic [AW-1:0] WADDR,
   input  logic [DW-1:0] WDATA,
   input  logic          RE,
   input  logic [AW-1:0] RADDR_A,
   input  logic [AW-1:0] RADDR_B,
   output logic [DW-1:0] RDATA_A,
   output logic [DW-1:0] RDATA_B,
   output logic          READY
);

   localparam logic [AW:0] c_last = (AW+1)'((2**AW) - 1);

   state_e        r_state;
   logic [AW:0]   r_ptr;
   logic [DW-1:0] r_rdata_a;
   logic [DW-1:0] r_rdata_b;

   logic          w_arr_we;
   logic [AW-1:0] w_arr_waddr;
   logic [DW-1:0] w_arr_wdata;
   logic [DW-1:0] w_arr_rdata_a;
   logic [DW-1:0] w_arr_rdata_b;
   logic          w_byp_a;
   logic          w_byp_b;

   // The sweep owns the write port until every entry has been zeroed.
   always_comb begin
      w_arr_we    = WE & RST_N;
      w_arr_waddr = WADDR;
      w_arr_wdata = WDATA;
      if (r_state == INIT) begin
         w_arr_we    = 1'b1;
         w_arr_waddr = r_ptr[AW-1:0];
         w_arr_wdata = '0;
      end
   end

   assign w_byp_a = WE && (RADDR_A == WADDR);
   assign w_byp_b = WE && (RADDR_B == WADDR);

   reg_file_array #(
      .DW (DW),
      .AW (AW)
   ) u_array (
      .i_clk     (CLK),
      .i_we      (w_arr_we),
      .i_waddr   (w_arr_waddr),
      .i_wdata   (w_arr_wdata),
      .i_raddr_a (RADDR_A),
      .i_raddr_b (RADDR_B),
      .o_rdata_a (w_arr_rdata_a),
      .o_rdata_b (w_arr_rdata_b)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state   <= INIT;
         r_ptr     <= '0;
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         case (r_state)
            INIT: begin
               r_ptr     <= r_ptr + 1'b1;
               r_rdata_a <= '0;
               r_rdata_b <= '0;
               if (r_ptr == c_last) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (RE) begin
                  r_rdata_a <= w_byp_a ? WDATA : w_arr_rdata_a;
                  r_rdata_b <= w_byp_b ? WDATA : w_arr_rdata_b;
               end
            end
            default: begin
               r_state <= INIT;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   assign RDATA_A = r_rdata_a;
   assign RDATA_B = r_rdata_b;
   assign READY   = (r_state == RUN);

endmodule : reg_file_rw

`default_nettype wire
